// File: rtl/reg_slv_if.sv
// reg_slv_if: APB3 responder for a register block.
// Issues one-cycle per-register strobes and returns read-back or external data.
module reg_slv_if #(
   parameter int                 ADDR_WIDTH = 16,
   parameter int                 DATA_WIDTH = 32,
   parameter int                 REG_CNT    = 8,
   parameter logic [REG_CNT-1:0] EXT_MASK   = '0,
   parameter int                 TIMEOUT    = 255
) (
   input  logic                          clk,
   input  logic                          sync_rst,
   input  logic                          psel,
   input  logic                          penable,
   input  logic                          pwrite,
   input  logic [ADDR_WIDTH-1:0]         paddr,
   input  logic [DATA_WIDTH-1:0]         pwdata,
   output logic [DATA_WIDTH-1:0]         prdata,
   output logic                          pready,
   output logic                          pslverr,
   output logic [REG_CNT-1:0]            reg_sw_rd,
   output logic [REG_CNT-1:0]            reg_sw_wr,
   output logic [DATA_WIDTH-1:0]         reg_wr_data,
   input  logic [REG_CNT*DATA_WIDTH-1:0] reg_rd_data,
   input  logic [REG_CNT-1:0]            ext_ack,
   input  logic [DATA_WIDTH-1:0]         ext_rd_data
);

   localparam int ADDR_LSB = $clog2(DATA_WIDTH / 8);
   localparam int IW       = ADDR_WIDTH - ADDR_LSB;
   localparam int CW       = $clog2(TIMEOUT + 1);

   typedef enum logic [1:0] {IDLE, ACCESS, WAIT_EXT, RESP} state_t;

   state_t                state, state_n;
   logic [IW-1:0]         idx, idx_n;
   logic                  write, write_n;
   logic [CW-1:0]         cnt, cnt_n;
   logic [DATA_WIDTH-1:0] prdata_n, wdata_n, rd_word;
   logic                  pready_n, pslverr_n;
   logic [REG_CNT-1:0]    rd_n, wr_n, stb;
   logic [IW-1:0]         a_idx;
   logic                  hit, ext, ack;

   assign a_idx = paddr[ADDR_WIDTH-1:ADDR_LSB];

   // Byte-lane bits below the word offset carry no meaning here.
   if (ADDR_LSB > 0) begin : g_lsb
      logic unused_lsb;
      assign unused_lsb = ^paddr[ADDR_LSB-1:0];
   end

   // Decode the incoming address and the latched index into per-register selects.
   always_comb begin
      stb     = '0;
      hit     = 1'b0;
      ext     = 1'b0;
      ack     = 1'b0;
      rd_word = '0;
      for (int i = 0; i < REG_CNT; i++) begin
         stb[i] = (a_idx == IW'(i));
         if (idx == IW'(i)) begin
            hit     = 1'b1;
            ext     = EXT_MASK[i];
            ack     = ext_ack[i];
            rd_word = reg_rd_data[i*DATA_WIDTH +: DATA_WIDTH];
         end
      end
   end

   // Next-state and next-output logic; every output leaves this block as a register input.
   always_comb begin
      state_n   = state;
      idx_n     = idx;
      write_n   = write;
      cnt_n     = cnt;
      prdata_n  = prdata;
      pslverr_n = pslverr;
      pready_n  = 1'b0;
      rd_n      = '0;
      wr_n      = '0;
      wdata_n   = reg_wr_data;
      unique case (state)
         IDLE: begin
            if (psel && !penable) begin
               idx_n   = a_idx;
               write_n = pwrite;
               wdata_n = pwdata;
               if (pwrite) wr_n = stb;
               else        rd_n = stb;
               state_n = ACCESS;
            end
         end
         ACCESS: begin
            if (!psel) begin
               state_n = IDLE;
            end else if (!hit) begin
               prdata_n  = '0;
               pslverr_n = 1'b1;
               pready_n  = 1'b1;
               state_n   = RESP;
            end else if (ext) begin
               cnt_n   = '0;
               state_n = WAIT_EXT;
            end else begin
               prdata_n  = write ? '0 : rd_word;
               pslverr_n = 1'b0;
               pready_n  = 1'b1;
               state_n   = RESP;
            end
         end
         WAIT_EXT: begin
            if (!psel) begin
               state_n = IDLE;
            end else if (ack) begin
               prdata_n  = write ? '0 : ext_rd_data;
               pslverr_n = 1'b0;
               pready_n  = 1'b1;
               state_n   = RESP;
            end else if (cnt == CW'(TIMEOUT)) begin
               prdata_n  = '0;
               pslverr_n = 1'b1;
               pready_n  = 1'b1;
               state_n   = RESP;
            end else begin
               cnt_n = cnt + 1'b1;
            end
         end
         RESP: state_n = IDLE;
         default: state_n = IDLE;
      endcase
   end

   // State and registered outputs; reset discards any transfer in flight.
   always_ff @(posedge clk) begin
      if (sync_rst) begin
         state       <= IDLE;
         idx         <= '0;
         write       <= 1'b0;
         cnt         <= '0;
         prdata      <= '0;
         pready      <= 1'b0;
         pslverr     <= 1'b0;
         reg_sw_rd   <= '0;
         reg_sw_wr   <= '0;
         reg_wr_data <= '0;
      end else begin
         state       <= state_n;
         idx         <= idx_n;
         write       <= write_n;
         cnt         <= cnt_n;
         prdata      <= prdata_n;
         pready      <= pready_n;
         pslverr     <= pslverr_n;
         reg_sw_rd   <= rd_n;
         reg_sw_wr   <= wr_n;
         reg_wr_data <= wdata_n;
      end
   end

endmodule

// File: tb/tb_reg_slv_if.sv
// tb_reg_slv_if: bench for reg_slv_if with register 7 external, timeout 4.
// Register 5 behaves as read-to-clear in the emulated register array.
module tb_reg_slv_if;

   localparam int TO = 4;

   logic          clk = 1'b0;
   logic          sync_rst;
   logic          psel, penable, pwrite;
   logic [15:0]   paddr;
   logic [31:0]   pwdata, prdata, reg_wr_data, ext_rd_data;
   logic          pready, pslverr;
   logic [7:0]    reg_sw_rd, reg_sw_wr, ext_ack;
   logic [255:0]  reg_rd_data;
   logic [31:0]   regval [8];
   logic [7:0]    plan [64];
   logic [31:0]   mdl [8];
   int            checks = 0;
   int            errors = 0;

   always #5 clk = ~clk;

   reg_slv_if #(
      .ADDR_WIDTH(16), .DATA_WIDTH(32), .REG_CNT(8),
      .EXT_MASK(8'h80), .TIMEOUT(TO)
   ) dut (
      .clk(clk), .sync_rst(sync_rst),
      .psel(psel), .penable(penable), .pwrite(pwrite),
      .paddr(paddr), .pwdata(pwdata),
      .prdata(prdata), .pready(pready), .pslverr(pslverr),
      .reg_sw_rd(reg_sw_rd), .reg_sw_wr(reg_sw_wr),
      .reg_wr_data(reg_wr_data), .reg_rd_data(reg_rd_data),
      .ext_ack(ext_ack), .ext_rd_data(ext_rd_data)
   );

   // Emulated field storage: strobed writes, register 5 clears on read.
   always @(posedge clk) begin
      for (int i = 0; i < 8; i++) begin
         if (sync_rst) regval[i] <= '0;
         else if (reg_sw_wr[i]) regval[i] <= reg_wr_data;
         else if (reg_sw_rd[i] && i == 5) regval[i] <= '0;
      end
   end

   // Present the register array to the DUT.
   always_comb begin
      for (int i = 0; i < 8; i++) reg_rd_data[i*32 +: 32] = regval[i];
   end

   function automatic void chk(string nm, logic [63:0] act, logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endfunction

   task automatic xfer(input logic w, input logic [15:0] a, input logic [31:0] d,
                       output int rdy, output logic [31:0] rd, output logic err,
                       output int nstb, output int stb_at, output logic [7:0] srd,
                       output logic [7:0] swr, output logic [31:0] wd);
      int n;
      n = 0; rdy = -1; rd = '0; err = 1'b0; nstb = 0; stb_at = -1;
      srd = '0; swr = '0; wd = '0;
      psel = 1'b1; penable = 1'b0; pwrite = w; paddr = a; pwdata = d;
      ext_ack = plan[0];
      while (rdy < 0 && n < 40) begin
         @(negedge clk);
         if ((|reg_sw_rd) || (|reg_sw_wr)) begin
            nstb++; stb_at = n; srd = reg_sw_rd; swr = reg_sw_wr; wd = reg_wr_data;
         end
         if (pready) begin rdy = n; rd = prdata; err = pslverr; end
         @(posedge clk); #1;
         n++;
         penable = 1'b1;
         ext_ack = (n < 64) ? plan[n] : 8'h00;
      end
      psel = 1'b0; penable = 1'b0; ext_ack = '0;
   endtask

   task automatic run(input string nm, input logic w, input logic [15:0] a,
                      input logic [31:0] d, input logic [31:0] xd,
                      input int ack, input int nz, input logic [7:0] nzv,
                      input int e_rdy, input logic [31:0] e_rd, input logic e_err,
                      input logic [7:0] e_srd, input logic [7:0] e_swr);
      int rdy, nstb, stb_at;
      logic [31:0] rd, wd;
      logic err;
      logic [7:0] srd, swr;
      for (int k = 0; k < 64; k++) plan[k] = '0;
      if (ack >= 0) plan[ack] = plan[ack] | 8'h80;
      if (nz >= 0) plan[nz] = plan[nz] | nzv;
      ext_rd_data = xd;
      xfer(w, a, d, rdy, rd, err, nstb, stb_at, srd, swr, wd);
      chk({nm, ".pready_cycle"}, 64'(rdy), 64'(e_rdy));
      chk({nm, ".prdata"}, rd, e_rd);
      chk({nm, ".pslverr"}, err, e_err);
      chk({nm, ".strobes"}, 64'(nstb), ((e_srd | e_swr) != 0) ? 64'd1 : 64'd0);
      if ((e_srd | e_swr) != 0) begin
         chk({nm, ".strobe_cycle"}, 64'(stb_at), 64'd1);
         chk({nm, ".strobe_vec"}, {srd, swr}, {e_srd, e_swr});
         if (w) chk({nm, ".wr_data"}, wd, d);
      end
   endtask

   task automatic quiet(input int n, input string nm);
      int seen;
      seen = 0;
      repeat (n) begin
         @(negedge clk);
         if (pready || (|reg_sw_rd) || (|reg_sw_wr)) seen++;
         @(posedge clk); #1;
      end
      chk(nm, 64'(seen), 64'd0);
   endtask

   typedef struct {
      logic        w;
      logic [15:0] a;
      logic [31:0] d;
      logic [31:0] xd;
      int          ack;
      int          nz;
      int          rdy;
      logic [31:0] rd;
      logic        err;
      logic [7:0]  srd;
      logic [7:0]  swr;
   } vec_t;

   vec_t vt [15];

   initial begin
      vt[0]  = '{1, 16'h0008, 32'hDEADBEEF, 0,          -1, -1, 2, 0,            0, 8'h00, 8'h04};
      vt[1]  = '{0, 16'h0008, 0,            0,          -1, -1, 2, 32'hDEADBEEF, 0, 8'h04, 8'h00};
      vt[2]  = '{0, 16'h0020, 0,            0,          -1, -1, 2, 0,            1, 8'h00, 8'h00};
      vt[3]  = '{0, 16'h001C, 0,            32'h1234,    4,  3, 5, 32'h1234,     0, 8'h80, 8'h00};
      vt[4]  = '{1, 16'h001C, 32'hA5A5,     0,          -1, -1, 7, 0,            1, 8'h00, 8'h80};
      vt[5]  = '{0, 16'h000B, 0,            0,          -1, -1, 2, 32'hDEADBEEF, 0, 8'h04, 8'h00};
      vt[6]  = '{1, 16'h0014, 32'h55AA,     0,          -1, -1, 2, 0,            0, 8'h00, 8'h20};
      vt[7]  = '{0, 16'h0014, 0,            0,          -1, -1, 2, 32'h55AA,     0, 8'h20, 8'h00};
      vt[8]  = '{0, 16'h0014, 0,            0,          -1, -1, 2, 0,            0, 8'h20, 8'h00};
      vt[9]  = '{0, 16'h001C, 0,            32'hCAFE,    2, -1, 3, 32'hCAFE,     0, 8'h80, 8'h00};
      vt[10] = '{1, 16'h001C, 32'h99,       0,           6, -1, 7, 0,            0, 8'h00, 8'h80};
      vt[11] = '{0, 16'h001C, 0,            32'h77,      7, -1, 7, 0,            1, 8'h80, 8'h00};
      vt[12] = '{0, 16'hFFFC, 0,            0,          -1, -1, 2, 0,            1, 8'h00, 8'h00};
      vt[13] = '{1, 16'h0001, 32'h0BADF00D, 0,          -1, -1, 2, 0,            0, 8'h00, 8'h01};
      vt[14] = '{0, 16'h0000, 0,            0,          -1, -1, 2, 32'h0BADF00D, 0, 8'h01, 8'h00};

      sync_rst = 1'b1; psel = 0; penable = 0; pwrite = 0;
      paddr = '0; pwdata = '0; ext_ack = '0; ext_rd_data = '0;
      repeat (3) @(posedge clk);
      #1 sync_rst = 1'b0;
      @(negedge clk);
      chk("reset.ctl", {pready, pslverr, reg_sw_rd, reg_sw_wr}, 0);
      chk("reset.data", {prdata, reg_wr_data}, 0);
      @(posedge clk); #1;

      // Table vectors, issued back to back.
      for (int i = 0; i < 15; i++)
         run($sformatf("vec%0d", i), vt[i].w, vt[i].a, vt[i].d, vt[i].xd,
             vt[i].ack, vt[i].nz, 8'h40, vt[i].rdy, vt[i].rd, vt[i].err,
             vt[i].srd, vt[i].swr);

      // Late ack after a timeout is ignored.
      run("late.xfer", 1, 16'h001C, 32'h1, 0, -1, -1, 8'h00,
          2 + TO + 1, 0, 1, 8'h00, 8'h80);
      ext_ack = 8'h80;
      @(negedge clk);
      chk("late.no_pready", pready, 0);
      @(posedge clk); #1 ext_ack = '0;
      quiet(5, "late.quiet");

      // Abort: psel dropped while waiting on the external register.
      psel = 1; penable = 0; pwrite = 0; paddr = 16'h001C;
      @(posedge clk); #1 penable = 1;
      @(posedge clk); #1;
      @(posedge clk); #1 psel = 0; penable = 0;
      @(posedge clk); #1 ext_ack = 8'h80;
      @(posedge clk); #1 ext_ack = '0;
      quiet(8, "abort.quiet");
      run("abort.next", 0, 16'h0008, 0, 0, -1, -1, 8'h00,
          2, 32'hDEADBEEF, 0, 8'h04, 8'h00);

      // Reset during WAIT_EXT clears everything and kills the transfer.
      psel = 1; penable = 0; pwrite = 0; paddr = 16'h001C;
      @(posedge clk); #1 penable = 1;
      @(posedge clk); #1;
      @(posedge clk); #1 sync_rst = 1;
      @(posedge clk); #1 sync_rst = 0;
      @(negedge clk);
      chk("rst_wait.ctl", {pready, pslverr, reg_sw_rd, reg_sw_wr}, 0);
      chk("rst_wait.data", {prdata, reg_wr_data}, 0);
      @(posedge clk); #1;
      quiet(6, "rst_wait.quiet");
      psel = 0; penable = 0;
      @(posedge clk); #1;

      // Randomized traffic against a transaction-level model.
      for (int k = 0; k < 8; k++) mdl[k] = '0;
      for (int t = 0; t < 80; t++) begin
         int idx, ack, nz, e_rdy;
         logic w, e_err;
         logic [15:0] a;
         logic [31:0] d, xd, e_rd;
         logic [7:0] e_srd, e_swr, nzv;
         idx = int'($urandom_range(0, 9));
         w   = 1'($urandom_range(0, 1));
         a   = 16'(idx * 4 + int'($urandom_range(0, 3)));
         d   = $urandom;
         xd  = $urandom;
         ack = (idx == 7) ? int'($urandom_range(0, 8)) : -1;
         nz  = int'($urandom_range(0, 8));
         nzv = 8'($urandom_range(0, 127));
         e_srd = '0; e_swr = '0; e_rd = '0; e_err = 1'b0; e_rdy = 2;
         if (idx >= 8) begin
            e_err = 1'b1;
         end else begin
            if (w) e_swr[idx] = 1'b1;
            else   e_srd[idx] = 1'b1;
            if (idx == 7) begin
               if (ack >= 2 && ack <= 2 + TO) begin
                  e_rdy = ack + 1;
                  e_rd  = w ? 32'h0 : xd;
               end else begin
                  e_rdy = 2 + TO + 1;
                  e_err = 1'b1;
               end
            end else begin
               e_rd = w ? 32'h0 : mdl[idx];
               if (w) mdl[idx] = d;
               else if (idx == 5) mdl[idx] = '0;
            end
         end
         run($sformatf("rnd%0d", t), w, a, d, xd, ack, nz, nzv,
             e_rdy, e_rd, e_err, e_srd, e_swr);
         repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/reg_slv_if.md
# reg_slv_if

Bus-side responder for the register block: accepts APB3 transactions and converts each into a single-cycle per-register `sw_rd`/`sw_wr` strobe plus write data for the field-level `sw_ctrl` instances. It then collects the field read-back, or an external register's acknowledged data, and returns `pready`/`prdata`/`pslverr` to the initiator. Wait states come from a small FSM. External registers get a bounded-timeout handshake. It sits between the system bus and the register array, one instance per register block.

## Interface
- `ADDR_WIDTH`, 16, APB address width.
- `DATA_WIDTH`, 32, register/bus data width; must be 8, 16, 32 or 64.
- `REG_CNT`, 8, number of registers, word-aligned from offset 0.
- `EXT_MASK`, {REG_CNT{1'b0}}, bit i = 1 marks register i as external (handshaked).
- `TIMEOUT`, 255, cycles to wait for `ext_ack` before an error response; must be ≥ 1.

Ports:
- `clk`  in  1  clock.
- `sync_rst`  in  1  synchronous, active-high reset.
- `psel`, `penable`, `pwrite`  in  1 each  APB3 control.
- `paddr`  in  ADDR_WIDTH  byte address.
- `pwdata`  in  DATA_WIDTH  write data.
- `prdata`  out  DATA_WIDTH  read data (registered).
- `pready`  out  1  transfer complete (registered).
- `pslverr`  out  1  error response (registered).
- `reg_sw_rd`  out  REG_CNT  one-hot read strobe.
- `reg_sw_wr`  out  REG_CNT  one-hot write strobe.
- `reg_wr_data`  out  DATA_WIDTH  latched write data.
- `reg_rd_data`  in  REG_CNT*DATA_WIDTH  concatenated register values; register i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
- `ext_ack`  in  REG_CNT  external register done.
- `ext_rd_data`  in  DATA_WIDTH  external read data, valid with `ext_ack`.

## Operation
- Address decode:
  - `idx = paddr[ADDR_WIDTH-1:ADDR_LSB]`, where `ADDR_LSB = $clog2(DATA_WIDTH/8)`.
  - Low address bits are ignored.
  - `idx >= REG_CNT` is out of range.
- FSM states are IDLE, ACCESS, WAIT_EXT, RESP.
- IDLE:
  - On `psel & ~penable` (setup phase), latch `idx`, `pwrite` and `pwdata` (into `reg_wr_data`), then go to ACCESS.
- ACCESS (exactly one cycle):
  - In range: assert `reg_sw_rd[idx]` or `reg_sw_wr[idx]` for this single cycle.
  - Internal register: capture `reg_rd_data[idx]` (pre-modification value, so RCLR/RSET fields return their old value) into `prdata` on reads; write `prdata=0` on writes. Next state RESP, `pslverr=0`.
  - External register: next state WAIT_EXT, timeout counter cleared.
  - Out of range: no strobe, `prdata=0`, `pslverr=1`, next state RESP.
- WAIT_EXT:
  - On `ext_ack[idx]`: capture `ext_rd_data` on reads (0 on writes), `pslverr=0`, go to RESP.
  - `ext_ack` bits for other indices are ignored.
  - When the counter reaches TIMEOUT without ack: `prdata=0`, `pslverr=1`, go to RESP.
  - An ack that arrives after timeout is ignored.
- RESP:
  - `pready=1` for one cycle, then IDLE.
  - `prdata` and `pslverr` hold their values until the next transfer's capture.
- Abort: if `psel` falls while in ACCESS or WAIT_EXT, return to IDLE with no `pready`. A strobe already issued is not retracted.
- `reg_sw_rd | reg_sw_wr` is never more than one-hot, and at most one strobe is issued per APB transfer.

## Timing
- Reset (`sync_rst=1` at a `clk` edge):
  - `prdata=0`, `pready=0`, `pslverr=0`, `reg_sw_rd=0`, `reg_sw_wr=0`, `reg_wr_data=0`, counter 0, state IDLE.
  - Reset overrides any in-flight transfer; no strobe or `pready` is produced afterwards for that transfer.
- Strobes are registered. Setup at edge T0 means the strobe is high during cycle T1, which coincides with the first `penable` cycle.
- Internal or error transfer: `pready` high in cycle T2, so there is exactly one wait state.
- External transfer: `ext_ack` sampled in cycle Tk means `pready` in cycle Tk+1. The earliest case is ack in T2 and `pready` in T3.
- Timeout: WAIT_EXT is entered in T2 and the counter increments each WAIT_EXT cycle. Error `pready` occurs in cycle T2+TIMEOUT+1.
- Back-to-back transfers: a new setup is accepted in the cycle immediately after `pready`. No other idle gap is required.

## Test plan
- Internal write then read:
  - Write `paddr=0x8`, `pwdata=0xDEADBEEF` → `reg_sw_wr=8'b0000_0100` for exactly one cycle in T1, `reg_wr_data=0xDEADBEEF`, `pready` in T2, `pslverr=0`.
  - Read of the same register with `reg_rd_data` slice 2 = 0xDEADBEEF → `prdata=0xDEADBEEF` in T2.
- Out of range: read `paddr=0x20` with `REG_CNT=8` → no strobe, `pready` in T2 with `pslverr=1`, `prdata=0`.
- External ack: `EXT_MASK=8'h80`, read `paddr=0x1C`, `ext_ack[7]` in T4 with `ext_rd_data=0x1234` → `pready` in T5, `prdata=0x1234`, `pslverr=0`. An `ext_ack[6]` pulse in T3 has no effect.
- Timeout: `TIMEOUT=4`, external write with no ack → `pready` and `pslverr=1` in T7. A late `ext_ack` in T8 is ignored and the state is IDLE.
- Reset and abort:
  - Assert `sync_rst` in WAIT_EXT → all outputs 0 next cycle and no `pready` follows.
  - Drop `psel` in WAIT_EXT → IDLE, no `pready`; the next transfer completes normally.
- Back-to-back: three consecutive reads with no gap → three single-cycle strobes and three `pready` pulses, each 2 cycles after its setup.
